mul_exec_unit: RTL and testbench
================================

MUL_EXEC_UNIT -- requirements
Module: mul_exec_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand and result width.
REQ-002 SHALL have parameter PREG_W, default 6, physical register index width.
REQ-003 SHALL have parameter BMASK_W, default 4, branch-mask width; BNUM_W = clog2(BMASK_W).
REQ-004 SHALL have parameter ROB_W, default 5, ROB index width.
REQ-005 SHALL have port clock, input, 1, single clock, all state on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous, active-low (asserted when 0).
REQ-007 SHALL have port is_valid, input, 1, an issued multiply packet is present.
REQ-008 SHALL have ports is_prs1_value / is_prs2_value, input, XLEN each, source operands.
REQ-009 SHALL have port is_func, input, 2, 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-010 SHALL have ports is_p_dest_reg_idx (input, PREG_W), is_b_mask (input, BMASK_W) and is_rob_tail (input, ROB_W), carrying the packet tags.
REQ-011 SHALL have port mul_busy, output, 1, unit cannot accept a packet this cycle.
REQ-012 SHALL have ports clean_brat_en (input, 1) and clean_brat_num (input, BNUM_W), squashing on a mispredict.
REQ-013 SHALL have ports clean_bit_brat_en (input, 1) and clean_bit_num (input, BNUM_W), clearing a mask bit on branch resolve.
REQ-014 SHALL have port cdb_grant, input, 1, the writeback arbiter accepts the current result.
REQ-015 SHALL have result ports mul_out_valid (output, 1), mul_out_value (output, XLEN), mul_out_p_dest (output, PREG_W), mul_out_rob (output, ROB_W) and mul_out_b_mask (output, BMASK_W).

Function
REQ-016 SHALL implement a 4-stage pipeline S1..S4.
- Each stage holds: valid, operands, func, partial product (2*XLEN), dest, rob, b_mask.
- Each stage accumulates XLEN/4 multiplier bits.
REQ-017 SHALL compute the 2*XLEN product with operand sign handling as follows.
- MUL, MULH: rs1 and rs2 both signed.
- MULHSU: rs1 signed, rs2 unsigned.
- MULHU: rs1 and rs2 both unsigned.
- MUL returns the low XLEN bits; the other three functions return the high XLEN bits.
REQ-018 SHALL define advance = !S4.valid || cdb_grant.
REQ-019 SHALL drive mul_busy = !advance, combinationally.
REQ-020 SHALL handle issue as follows.
- A packet is accepted into S1 at the edge when is_valid=1 and mul_busy=0.
- A packet presented while mul_busy=1 is ignored and not retained.
REQ-021 SHALL, when advance=1, shift S1->S2->S3->S4 at each edge; when advance=0, all stages hold.
REQ-022 SHALL give 4-cycle latency: a packet accepted in cycle t appears with mul_out_valid=1 in cycle t+4 if no stall occurs; throughput is 1 per cycle.
REQ-023 SHALL drive mul_out_valid = S4.valid && !(clean_brat_en && S4.b_mask[clean_brat_num]).
REQ-024 SHALL drive mul_out_value, mul_out_p_dest and mul_out_rob from S4; all result outputs are 0 when S4.valid=0.
REQ-025 SHALL drive mul_out_b_mask = S4.b_mask with bit clean_bit_num cleared when clean_bit_brat_en=1.
REQ-026 SHALL, when clean_brat_en=1, clear at that edge the valid bit of every stage whose b_mask[clean_brat_num]=1.
- This applies to S1..S4 whether stalled or not.
- An incoming packet with that bit set is not accepted.
REQ-027 SHALL, when clean_bit_brat_en=1, clear b_mask[clean_bit_num] at that edge in every stored stage and in the incoming packet.
REQ-028 SHALL apply squash and bit-clear together when both occur in the same cycle; squash is evaluated on the mask before the clear.
REQ-029 SHALL, for cdb_grant with a squashed S4, not deliver a result; S4 is emptied.
REQ-030 SHALL not move or collapse bubbles independently: the pipeline advances as a whole.

Reset
REQ-031 SHALL, while reset=0, immediately clear all stage valids and drive all outputs to 0 (mul_busy=0).
- This includes reset asserted mid-operation.
- In-flight packets are discarded.
REQ-032 SHALL accept a packet in the first cycle after reset is released.

Verification
REQ-033 SHALL cover MUL issue: rs1=0xFFFFFFFE, rs2=3, dest=9, rob=4, cdb_grant=1 -> 4 cycles later mul_out_valid=1, value=0xFFFFFFFA, p_dest=9, rob=4.
REQ-034 SHALL cover back-to-back MULH(0xFFFFFFFE,3), MULHU(0xFFFFFFFF,0xFFFFFFFF) and MULHSU(0xFFFFFFFF,2) -> results 0xFFFFFFFF, 0xFFFFFFFE and 0xFFFFFFFF on three consecutive cycles.
REQ-035 SHALL cover stall: fill the pipe, then hold cdb_grant=0 for 3 cycles.
- mul_busy=1 throughout; the packet issued during the stall is dropped.
- The S4 result is held stable.
- After grant, results follow in order with no loss.
REQ-036 SHALL cover squash: packets with masks 0001, 0010, 0001 in flight, then clean_brat_en=1 with num=0.
- Only the 0010 packet emerges.
- mul_out_valid=0 in the same cycle if the squashed packet is in S4.
REQ-037 SHALL cover bit-clear: packet with mask 0110, clean_bit_brat_en=1 with num=1 -> emerges with mask 0100; a later squash with num=1 does not kill it.
REQ-038 SHALL cover reset: assert reset=0 with 3 packets in flight -> outputs 0 at once, nothing emerges after release, and a new packet completes in 4 cycles.

Source files
------------

// File: rtl/mul_exec_unit.sv
// Four-stage pipelined integer multiplier (MUL/MULH/MULHSU/MULHU) with branch-mask
// squash and mask-bit clearing; the pipeline advances as a whole when S4 drains.
module mul_exec_unit #(
    parameter int XLEN    = 32,
    parameter int PREG_W  = 6,
    parameter int BMASK_W = 4,
    parameter int ROB_W   = 5,
    localparam int BNUM_W = $clog2(BMASK_W)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 is_valid,
    input  logic [XLEN-1:0]      is_prs1_value,
    input  logic [XLEN-1:0]      is_prs2_value,
    input  logic [1:0]           is_func,
    input  logic [PREG_W-1:0]    is_p_dest_reg_idx,
    input  logic [BMASK_W-1:0]   is_b_mask,
    input  logic [ROB_W-1:0]     is_rob_tail,
    output logic                 mul_busy,
    input  logic                 clean_brat_en,
    input  logic [BNUM_W-1:0]    clean_brat_num,
    input  logic                 clean_bit_brat_en,
    input  logic [BNUM_W-1:0]    clean_bit_num,
    input  logic                 cdb_grant,
    output logic                 mul_out_valid,
    output logic [XLEN-1:0]      mul_out_value,
    output logic [PREG_W-1:0]    mul_out_p_dest,
    output logic [ROB_W-1:0]     mul_out_rob,
    output logic [BMASK_W-1:0]   mul_out_b_mask
);

    localparam int DW   = 2 * XLEN;
    localparam int Q    = XLEN / 4;
    localparam int NSTG = 4;

    typedef struct packed {
        logic [XLEN-1:0]    rs1;
        logic [XLEN-1:0]    rs2;
        logic [1:0]         func;
        logic [DW-1:0]      pp;
        logic [PREG_W-1:0]  dest;
        logic [ROB_W-1:0]   rob;
        logic [BMASK_W-1:0] mask;
    } stage_t;

    stage_t             stg_q [NSTG];
    stage_t             stg_d [NSTG];
    logic [NSTG-1:0]    vld_q;
    logic [NSTG-1:0]    vld_d;
    logic               advance;
    logic [BMASK_W-1:0] keep_mask;
    stage_t             s4;

    // Contribution of multiplier chunk idx; the top chunk carries negative weight
    // when rs2 is signed (MUL, MULH), everything is taken modulo 2^(2*XLEN).
    function automatic logic [DW-1:0] partial_product(
        input logic [XLEN-1:0] rs1,
        input logic [XLEN-1:0] rs2,
        input logic [1:0]      func,
        input int              idx
    );
        logic [DW-1:0] a_ext;
        logic [DW-1:0] b_ext;
        logic [Q-1:0]  chunk;
        a_ext = (func == 2'b11) ? {{XLEN{1'b0}}, rs1} : {{XLEN{rs1[XLEN-1]}}, rs1};
        chunk = rs2[idx*Q +: Q];
        b_ext = {{(DW-Q){1'b0}}, chunk};
        if (idx == NSTG - 1 && !func[1]) begin
            b_ext = {{(DW-Q){chunk[Q-1]}}, chunk};
        end
        return (a_ext * b_ext) << (idx * Q);
    endfunction

    always_comb begin
        advance   = !vld_q[NSTG-1] || cdb_grant;
        keep_mask = '1;
        if (clean_bit_brat_en) begin
            keep_mask[clean_bit_num] = 1'b0;
        end
        // Held stages still see squash and bit-clear; squash uses the pre-clear mask.
        for (int i = 0; i < NSTG; i++) begin
            vld_d[i]      = vld_q[i] && !(clean_brat_en && stg_q[i].mask[clean_brat_num]);
            stg_d[i]      = stg_q[i];
            stg_d[i].mask = stg_q[i].mask & keep_mask;
        end
        if (advance) begin
            vld_d[0]      = is_valid && !(clean_brat_en && is_b_mask[clean_brat_num]);
            stg_d[0].rs1  = is_prs1_value;
            stg_d[0].rs2  = is_prs2_value;
            stg_d[0].func = is_func;
            stg_d[0].pp   = partial_product(is_prs1_value, is_prs2_value, is_func, 0);
            stg_d[0].dest = is_p_dest_reg_idx;
            stg_d[0].rob  = is_rob_tail;
            stg_d[0].mask = is_b_mask & keep_mask;
            for (int i = 1; i < NSTG; i++) begin
                vld_d[i]      = vld_q[i-1] && !(clean_brat_en && stg_q[i-1].mask[clean_brat_num]);
                stg_d[i]      = stg_q[i-1];
                stg_d[i].pp   = stg_q[i-1].pp
                              + partial_product(stg_q[i-1].rs1, stg_q[i-1].rs2, stg_q[i-1].func, i);
                stg_d[i].mask = stg_q[i-1].mask & keep_mask;
            end
        end
    end

    always_comb begin
        s4             = stg_q[NSTG-1];
        mul_busy       = !advance;
        mul_out_valid  = vld_q[NSTG-1] && !(clean_brat_en && s4.mask[clean_brat_num]);
        mul_out_value  = '0;
        mul_out_p_dest = '0;
        mul_out_rob    = '0;
        mul_out_b_mask = '0;
        if (vld_q[NSTG-1]) begin
            mul_out_value  = (s4.func == 2'b00) ? s4.pp[XLEN-1:0] : s4.pp[DW-1:XLEN];
            mul_out_p_dest = s4.dest;
            mul_out_rob    = s4.rob;
            mul_out_b_mask = s4.mask & keep_mask;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // Payload is qualified by the valids, so it carries no reset.
    always_ff @(posedge clock) begin
        stg_q <= stg_d;
    end

endmodule

// File: tb/tb_mul_exec_unit.sv
// Directed and randomized bench for mul_exec_unit against a slot-level result model.
module tb_mul_exec_unit;

    logic        clock;
    logic        reset;
    logic        is_valid;
    logic [31:0] is_prs1_value;
    logic [31:0] is_prs2_value;
    logic [1:0]  is_func;
    logic [5:0]  is_p_dest_reg_idx;
    logic [3:0]  is_b_mask;
    logic [4:0]  is_rob_tail;
    logic        mul_busy;
    logic        clean_brat_en;
    logic [1:0]  clean_brat_num;
    logic        clean_bit_brat_en;
    logic [1:0]  clean_bit_num;
    logic        cdb_grant;
    logic        mul_out_valid;
    logic [31:0] mul_out_value;
    logic [5:0]  mul_out_p_dest;
    logic [4:0]  mul_out_rob;
    logic [3:0]  mul_out_b_mask;

    mul_exec_unit dut (
        .clock             (clock),
        .reset             (reset),
        .is_valid          (is_valid),
        .is_prs1_value     (is_prs1_value),
        .is_prs2_value     (is_prs2_value),
        .is_func           (is_func),
        .is_p_dest_reg_idx (is_p_dest_reg_idx),
        .is_b_mask         (is_b_mask),
        .is_rob_tail       (is_rob_tail),
        .mul_busy          (mul_busy),
        .clean_brat_en     (clean_brat_en),
        .clean_brat_num    (clean_brat_num),
        .clean_bit_brat_en (clean_bit_brat_en),
        .clean_bit_num     (clean_bit_num),
        .cdb_grant         (cdb_grant),
        .mul_out_valid     (mul_out_valid),
        .mul_out_value     (mul_out_value),
        .mul_out_p_dest    (mul_out_p_dest),
        .mul_out_rob       (mul_out_rob),
        .mul_out_b_mask    (mul_out_b_mask)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // One model slot per cycle of latency, holding the finished result.
    typedef struct {
        bit          v;
        logic [31:0] val;
        logic [5:0]  dest;
        logic [4:0]  rob;
        logic [3:0]  mask;
    } ent_t;

    ent_t mdl     [4];
    ent_t mdl_nxt [4];
    int   checks = 0;
    int   passes = 0;

    function automatic logic [31:0] ref_mul(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [65:0] sa;
        logic signed [65:0] sb;
        logic signed [65:0] p;
        sa = (f == 2'b11) ? {34'b0, a} : {{34{a[31]}}, a};
        sb = f[1] ? {34'b0, b} : {{34{b[31]}}, b};
        p  = sa * sb;
        return (f == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            mdl[i] = '{default: 0};
        end
    endtask

    task automatic check_model();
        ent_t       s4;
        logic [3:0] keep;
        bit         adv;
        s4   = mdl[3];
        adv  = !s4.v || cdb_grant;
        keep = 4'hF;
        if (clean_bit_brat_en) keep[clean_bit_num] = 1'b0;
        chk("busy",      64'(mul_busy),      64'(!adv));
        chk("out_valid", 64'(mul_out_valid), 64'(s4.v && !(clean_brat_en && s4.mask[clean_brat_num])));
        chk("out_value", 64'(mul_out_value),  64'(s4.v ? s4.val  : 32'd0));
        chk("out_dest",  64'(mul_out_p_dest), 64'(s4.v ? s4.dest : 6'd0));
        chk("out_rob",   64'(mul_out_rob),    64'(s4.v ? s4.rob  : 5'd0));
        chk("out_mask",  64'(mul_out_b_mask), 64'(s4.v ? (s4.mask & keep) : 4'd0));
    endtask

    task automatic model_step();
        ent_t       src;
        ent_t       inc;
        logic [3:0] keep;
        bit         adv;
        keep = 4'hF;
        if (clean_bit_brat_en) keep[clean_bit_num] = 1'b0;
        adv  = !mdl[3].v || cdb_grant;
        inc.v    = is_valid;
        inc.val  = ref_mul(is_func, is_prs1_value, is_prs2_value);
        inc.dest = is_p_dest_reg_idx;
        inc.rob  = is_rob_tail;
        inc.mask = is_b_mask;
        for (int i = 0; i < 4; i++) begin
            if (!adv)        src = mdl[i];
            else if (i == 0) src = inc;
            else             src = mdl[i-1];
            mdl_nxt[i]      = src;
            mdl_nxt[i].v    = src.v && !(clean_brat_en && src.mask[clean_brat_num]);
            mdl_nxt[i].mask = src.mask & keep;
            if (!reset) mdl_nxt[i] = '{default: 0};
        end
    endtask

    task automatic tick();
        @(negedge clock);
        check_model();
        model_step();
        @(posedge clock);
        #1;
        mdl               = mdl_nxt;
        is_valid          = 1'b0;
        clean_brat_en     = 1'b0;
        clean_bit_brat_en = 1'b0;
    endtask

    task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] d, input logic [4:0] r, input logic [3:0] m);
        is_valid          = 1'b1;
        is_func           = f;
        is_prs1_value     = a;
        is_prs2_value     = b;
        is_p_dest_reg_idx = d;
        is_rob_tail       = r;
        is_b_mask         = m;
    endtask

    task automatic expect_result(input string tag, input logic [31:0] v);
        #1;
        chk({tag, "_valid"}, 64'(mul_out_valid), 64'd1);
        chk({tag, "_value"}, 64'(mul_out_value), 64'(v));
    endtask

    task automatic expect_all_zero(input string tag);
        chk({tag, "_busy"},  64'(mul_busy),       64'd0);
        chk({tag, "_valid"}, 64'(mul_out_valid),  64'd0);
        chk({tag, "_value"}, 64'(mul_out_value),  64'd0);
        chk({tag, "_dest"},  64'(mul_out_p_dest), 64'd0);
        chk({tag, "_rob"},   64'(mul_out_rob),    64'd0);
        chk({tag, "_mask"},  64'(mul_out_b_mask), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;  cdb_grant = 1'b0;  is_valid = 1'b0;
        is_prs1_value = '0;  is_prs2_value = '0;  is_func = '0;
        is_p_dest_reg_idx = '0;  is_b_mask = '0;  is_rob_tail = '0;
        clean_brat_en = 1'b0;  clean_brat_num = '0;
        clean_bit_brat_en = 1'b0;  clean_bit_num = '0;
        clear_model();
        #2;
        expect_all_zero("rst_init");
        tick(); tick();
        reset = 1'b1;
        cdb_grant = 1'b1;

        // MUL issued in the first cycle after reset release
        issue(2'b00, 32'hFFFF_FFFE, 32'd3, 6'd9, 5'd4, 4'b0000);
        tick(); tick(); tick(); tick();
        expect_result("mul", 32'hFFFF_FFFA);
        chk("mul_dest", 64'(mul_out_p_dest), 64'd9);
        chk("mul_rob",  64'(mul_out_rob),    64'd4);

        // back-to-back high-half functions
        issue(2'b01, 32'hFFFF_FFFE, 32'd3, 6'd1, 5'd1, 4'b0000); tick();
        issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd2, 5'd2, 4'b0000); tick();
        issue(2'b10, 32'hFFFF_FFFF, 32'd2, 6'd3, 5'd3, 4'b0000); tick();
        tick();
        expect_result("mulh", 32'hFFFF_FFFF);   tick();
        expect_result("mulhu", 32'hFFFF_FFFE);  tick();
        expect_result("mulhsu", 32'hFFFF_FFFF); tick();

        // stall with a full pipe
        issue(2'b00, 32'd7, 32'd6, 6'd1, 5'd1, 4'b0000); tick();
        issue(2'b00, 32'd5, 32'd5, 6'd2, 5'd2, 4'b0000); tick();
        issue(2'b01, 32'h8000_0000, 32'h8000_0000, 6'd3, 5'd3, 4'b0000); tick();
        issue(2'b11, 32'hFFFF_FFFF, 32'd2, 6'd4, 5'd4, 4'b0000); tick();
        cdb_grant = 1'b0;
        for (int k = 0; k < 3; k++) begin
            issue(2'b00, 32'd9, 32'd9, 6'd5, 5'd5, 4'b0000);
            #1;
            chk("stall_busy", 64'(mul_busy), 64'd1);
            chk("stall_hold", 64'(mul_out_value), 64'd42);
            tick();
        end
        cdb_grant = 1'b1;
        expect_result("stall_p0", 32'd42);        tick();
        expect_result("stall_p1", 32'd25);        tick();
        expect_result("stall_p2", 32'h4000_0000); tick();
        expect_result("stall_p3", 32'd1);         tick();
        #1 chk("stall_drop", 64'(mul_out_valid), 64'd0);
        tick();

        // squash on bit 0 while the first victim sits in S4
        issue(2'b00, 32'd2, 32'd3, 6'd6, 5'd6, 4'b0001); tick();
        issue(2'b00, 32'd4, 32'd5, 6'd7, 5'd7, 4'b0010); tick();
        issue(2'b00, 32'd6, 32'd7, 6'd8, 5'd8, 4'b0001); tick();
        tick();
        clean_brat_en = 1'b1;  clean_brat_num = 2'd0;
        #1 chk("sq_s4_valid", 64'(mul_out_valid), 64'd0);
        tick();
        expect_result("sq_survivor", 32'd20);
        chk("sq_survivor_dest", 64'(mul_out_p_dest), 64'd7);
        tick();
        #1 chk("sq_gone_a", 64'(mul_out_valid), 64'd0);
        tick();
        #1 chk("sq_gone_b", 64'(mul_out_valid), 64'd0);
        tick();

        // bit-clear then squash on the cleared bit
        issue(2'b00, 32'd3, 32'd3, 6'd10, 5'd10, 4'b0110); tick();
        clean_bit_brat_en = 1'b1;  clean_bit_num = 2'd1; tick();
        tick();
        clean_brat_en = 1'b1;  clean_brat_num = 2'd1; tick();
        expect_result("bc", 32'd9);
        chk("bc_mask", 64'(mul_out_b_mask), 64'h4);
        tick();

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            cdb_grant = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) < 6) begin
                issue(2'($urandom), pick(), pick(), 6'($urandom), 5'($urandom), 4'($urandom));
            end
            clean_brat_en     = ($urandom_range(0, 11) == 0);
            clean_brat_num    = 2'($urandom);
            clean_bit_brat_en = ($urandom_range(0, 7) == 0);
            clean_bit_num     = 2'($urandom);
            tick();
        end
        cdb_grant = 1'b1;
        for (int k = 0; k < 6; k++) tick();

        // reset with packets in flight and S4 stalled
        issue(2'b00, 32'd1, 32'd2, 6'd1, 5'd1, 4'b0000); tick();
        issue(2'b00, 32'd3, 32'd4, 6'd2, 5'd2, 4'b0000); tick();
        issue(2'b00, 32'd5, 32'd6, 6'd3, 5'd3, 4'b0000); tick();
        cdb_grant = 1'b0;
        tick();
        #1 chk("pre_rst_busy", 64'(mul_busy), 64'd1);
        reset = 1'b0;
        #1;
        expect_all_zero("rst_mid");
        clear_model();
        tick(); tick();
        reset = 1'b1;
        cdb_grant = 1'b1;
        issue(2'b00, 32'd11, 32'd13, 6'd12, 5'd12, 4'b0000);
        tick(); tick(); tick(); tick();
        expect_result("rst_new", 32'd143);
        tick();
        for (int k = 0; k < 4; k++) tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
